// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Start/Done handshake, invalid digits flagged on Error.
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BW     = 7
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [4*DIGITS-1:0]   BCD_In,
    output logic                  Busy,
    output logic                  Done,
    output logic [BW-1:0]         Bin_Out,
    output logic                  Error
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [W-1:0]    dig_q;
    logic [W-1:0]    bin_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    dig_tmp;
    logic [W-1:0]    dig_sh;
    logic [W-1:0]    bin_sh;
    logic            bad;
    logic            last;

    // Flag any input digit above 9
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (BCD_In[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then correct digits >= 8
    always_comb begin
        bin_sh  = {dig_q[0], bin_q[W-1:1]};
        dig_tmp = {1'b0, dig_q[W-1:1]};
        dig_sh  = dig_tmp;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_tmp[4*i +: 4] >= 4'd8) begin
                dig_sh[4*i +: 4] = dig_tmp[4*i +: 4] - 4'd3;
            end
        end
    end

    assign last = (cnt_q == CW'(W - 1));
    assign Busy = (state == SHIFT);
    assign Done = (state == DONE);

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    next_state = bad ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, iterate in SHIFT, publish result on exit
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            dig_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            Bin_Out <= '0;
            Error   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        if (bad) begin
                            Error   <= 1'b1;
                            Bin_Out <= '0;
                        end else begin
                            Error <= 1'b0;
                            dig_q <= BCD_In;
                            bin_q <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                SHIFT: begin
                    dig_q <= dig_sh;
                    bin_q <= bin_sh;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        Bin_Out <= BW'(bin_sh);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq.
// Covers 2-digit default and a 3-digit instance.
module tb_bcd_to_bin_seq;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  BCD_In;
    logic        Busy;
    logic        Done;
    logic [6:0]  Bin_Out;
    logic        Error;

    logic        p_Start;
    logic [11:0] p_BCD_In;
    logic        p_Busy;
    logic        p_Done;
    logic [9:0]  p_Bin_Out;
    logic        p_Error;

    int checks   = 0;
    int failures = 0;

    bcd_to_bin_seq dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .BCD_In  (BCD_In),
        .Busy    (Busy),
        .Done    (Done),
        .Bin_Out (Bin_Out),
        .Error   (Error)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BW(10)) dut3 (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (p_Start),
        .BCD_In  (p_BCD_In),
        .Busy    (p_Busy),
        .Done    (p_Done),
        .Bin_Out (p_Bin_Out),
        .Error   (p_Error)
    );

    always #5 Clock = ~Clock;

    // Pulse Start for one cycle, then count edges after the accepting
    // edge until Done is seen (edge_idx) and cycles with Busy high.
    task automatic run_conv(input logic [7:0] bcd,
                            output int edge_idx, output int busy_n);
        @(negedge Clock);
        BCD_In = bcd;
        Start  = 1'b1;
        @(negedge Clock);
        Start    = 1'b0;
        BCD_In   = 8'h77;
        edge_idx = 0;
        busy_n   = 0;
        while (!Done && edge_idx < 40) begin
            if (Busy) busy_n++;
            @(negedge Clock);
            edge_idx++;
        end
    endtask

    task automatic test_reset;
        Reset    = 1'b1;
        Start    = 1'b0;
        BCD_In   = 8'h00;
        p_Start  = 1'b0;
        p_BCD_In = 12'h000;
        repeat (2) @(negedge Clock);
        checks++;
        if ({Busy, Done, Error} !== 3'b000 || Bin_Out !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b bin=%0d, want 0 0 0 0",
                     Busy, Done, Error, Bin_Out);
        end
        checks++;
        if ({p_Busy, p_Done, p_Error} !== 3'b000 || p_Bin_Out !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs_p: got busy=%b done=%b err=%b bin=%0d, want 0 0 0 0",
                     p_Busy, p_Done, p_Error, p_Bin_Out);
        end
        Reset = 1'b0;
    endtask

    task automatic test_valid_42;
        int e, b;
        run_conv(8'h42, e, b);
        checks++;
        if (e !== 8) begin
            failures++;
            $display("FAIL lat_42: got %0d edges, want 8", e);
        end
        checks++;
        if (b !== 8) begin
            failures++;
            $display("FAIL busy_42: got %0d cycles, want 8", b);
        end
        checks++;
        if (Bin_Out !== 7'd42 || Error !== 1'b0) begin
            failures++;
            $display("FAIL val_42: got bin=%0d err=%b, want 42 0", Bin_Out, Error);
        end
        @(negedge Clock);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: got done=%b busy=%b, want 0 0", Done, Busy);
        end
    endtask

    task automatic test_boundary;
        int e, b;
        logic [7:0] vin  [4] = '{8'h99, 8'h00, 8'h09, 8'h10};
        logic [6:0] vexp [4] = '{7'd99, 7'd0, 7'd9, 7'd10};
        for (int i = 0; i < 4; i++) begin
            run_conv(vin[i], e, b);
            checks++;
            if (Bin_Out !== vexp[i] || e !== 8) begin
                failures++;
                $display("FAIL bound_%h: got bin=%0d edges=%0d, want %0d 8",
                         vin[i], Bin_Out, e, vexp[i]);
            end
        end
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                logic [7:0] v;
                logic [6:0] x;
                v = {t[3:0], o[3:0]};
                x = 7'(t * 10 + o);
                run_conv(v, e, b);
                checks++;
                if (Bin_Out !== x || Error !== 1'b0) begin
                    failures++;
                    $display("FAIL sweep_%h: got bin=%0d err=%b, want %0d 0",
                             v, Bin_Out, Error, x);
                end
            end
        end
    endtask

    task automatic test_invalid;
        int e, b;
        run_conv(8'h1A, e, b);
        checks++;
        if (e !== 0 || b !== 0) begin
            failures++;
            $display("FAIL inv_lat: got edges=%0d busy=%0d, want 0 0", e, b);
        end
        checks++;
        if (Error !== 1'b1 || Bin_Out !== 7'd0) begin
            failures++;
            $display("FAIL inv_val: got err=%b bin=%0d, want 1 0", Error, Bin_Out);
        end
        @(negedge Clock);
        checks++;
        if (Done !== 1'b0 || Error !== 1'b1) begin
            failures++;
            $display("FAIL inv_hold: got done=%b err=%b, want 0 1", Done, Error);
        end
        run_conv(8'h15, e, b);
        checks++;
        if (Error !== 1'b0 || Bin_Out !== 7'd15 || e !== 8) begin
            failures++;
            $display("FAIL after_inv: got err=%b bin=%0d edges=%0d, want 0 15 8",
                     Error, Bin_Out, e);
        end
    endtask

    task automatic test_start_while_busy;
        int dones;
        logic [6:0] prev;
        prev = Bin_Out;
        dones = 0;
        @(negedge Clock);
        BCD_In = 8'h42;
        Start  = 1'b1;
        @(negedge Clock);
        Start  = 1'b0;
        BCD_In = 8'h77;
        for (int i = 0; i < 20; i++) begin
            if (Done) dones++;
            if (i == 3) begin
                checks++;
                if (Bin_Out !== prev) begin
                    failures++;
                    $display("FAIL hold_mid: got bin=%0d, want %0d", Bin_Out, prev);
                end
            end
            Start = (i == 2 || i == 5);
            @(negedge Clock);
        end
        Start = 1'b0;
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL busy_ignore_cnt: got %0d done pulses, want 1", dones);
        end
        checks++;
        if (Bin_Out !== 7'd42) begin
            failures++;
            $display("FAIL busy_ignore_val: got bin=%0d, want 42", Bin_Out);
        end
    endtask

    task automatic test_back_to_back;
        int idx [$];
        @(negedge Clock);
        BCD_In = 8'h27;
        Start  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            if (Done) idx.push_back(i);
        end
        Start = 1'b0;
        checks++;
        if (idx.size() !== 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", idx.size());
        end else begin
            checks++;
            if (idx[0] !== 8 || idx[1] !== 18 || idx[2] !== 28) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d %0d %0d, want 8 18 28",
                         idx[0], idx[1], idx[2]);
            end
        end
        checks++;
        if (Bin_Out !== 7'd27) begin
            failures++;
            $display("FAIL b2b_val: got bin=%0d, want 27", Bin_Out);
        end
        repeat (3) @(negedge Clock);
    endtask

    task automatic test_reset_mid;
        int e, b, dones;
        @(negedge Clock);
        BCD_In = 8'h63;
        Start  = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        checks++;
        if (Busy !== 1'b1 || Bin_Out !== 7'd27) begin
            failures++;
            $display("FAIL pre_reset: got busy=%b bin=%0d, want 1 27", Busy, Bin_Out);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({Busy, Done, Error} !== 3'b000 || Bin_Out !== 7'd0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b done=%b err=%b bin=%0d, want 0 0 0 0",
                     Busy, Done, Error, Bin_Out);
        end
        @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (Done || Busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL no_done_after_reset: got %0d active cycles, want 0", dones);
        end
        run_conv(8'h63, e, b);
        checks++;
        if (Bin_Out !== 7'd63 || e !== 8) begin
            failures++;
            $display("FAIL post_reset_63: got bin=%0d edges=%0d, want 63 8", Bin_Out, e);
        end
    endtask

    task automatic test_param;
        int e;
        @(negedge Clock);
        p_BCD_In = 12'h999;
        p_Start  = 1'b1;
        @(negedge Clock);
        p_Start  = 1'b0;
        p_BCD_In = 12'h000;
        e = 0;
        while (!p_Done && e < 40) begin
            @(negedge Clock);
            e++;
        end
        checks++;
        if (e !== 12) begin
            failures++;
            $display("FAIL p_lat: got %0d edges, want 12", e);
        end
        checks++;
        if (p_Bin_Out !== 10'd999 || p_Error !== 1'b0) begin
            failures++;
            $display("FAIL p_val: got bin=%0d err=%b, want 999 0", p_Bin_Out, p_Error);
        end
    endtask

    initial begin
        test_reset();
        test_valid_42();
        test_boundary();
        test_invalid();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
